pipelined_addsub: RTL



---
 rtl/pipelined_addsub.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit two's-complement adder/subtractor whose carry
// chain is cut into STAGES equal chunks, one chunk per pipeline stage.
//
// Handshake: a beat transfers on a rising edge when valid && ready on that
// side. The input side accepts while in_ready = !stall, where
// stall = out_valid && !out_ready. A stall freezes every pipeline register,
// so a held result stays constant until the consumer takes it. Bubbles move
// down the pipe like real beats and are never collapsed.
//
// Register levels: level 0 captures A, B' (B or ~B), the carry-in and the
// valid bit on the accept edge. Level k (1..STAGES) adds chunk k-1 with the
// carry registered at level k-1. Level STAGES drives the outputs together
// with the ovf and zero flags.
module pipelined_addsub #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             C_out,
   output logic             ovf,
   output logic             zero
);

   localparam int CHUNK = WIDTH / STAGES;

   // Valid bit, chunk carry and partial sum per level.
   logic [STAGES:0]                  vld_q, vld_d;
   logic [STAGES:0]                  cy_q, cy_d;
   logic [STAGES:0][WIDTH-1:0]       sum_q, sum_d;
   // Operands are only needed up to the level feeding the last adder.
   logic [STAGES-1:0][WIDTH-1:0]     opa_q, opa_d;
   logic [STAGES-1:0][WIDTH-1:0]     opb_q, opb_d;
   logic                             ovf_q, ovf_d;
   logic                             zero_q, zero_d;

   logic                             stall;
   logic [CHUNK:0]                   part;
   logic                             msb_cin;

   // Global stall: the result at the head cannot leave, so nothing moves.
   always_comb begin
      stall    = vld_q[STAGES] && !out_ready;
      in_ready = !stall;
   end

   // Next state of every level: capture, per-chunk add, final flags.
   always_comb begin
      vld_d   = vld_q;
      cy_d    = cy_q;
      sum_d   = sum_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      part    = '0;
      msb_cin = 1'b0;
      if (!stall) begin
         // Level 0: subtract is A + ~B + 1, so C_in is ignored there.
         vld_d[0] = in_valid;
         opa_d[0] = A;
         opb_d[0] = sub ? ~B : B;
         cy_d[0]  = sub ? 1'b1 : C_in;
         sum_d[0] = '0;
         // Levels 1..STAGES: resolve one chunk each, carry into the next.
         for (int k = 1; k <= STAGES; k++) begin
            vld_d[k] = vld_q[k-1];
            part = {1'b0, opa_q[k-1][(k-1)*CHUNK +: CHUNK]}
                 + {1'b0, opb_q[k-1][(k-1)*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, cy_q[k-1]};
            sum_d[k] = sum_q[k-1];
            sum_d[k][(k-1)*CHUNK +: CHUNK] = part[CHUNK-1:0];
            cy_d[k]  = part[CHUNK];
         end
         // Operands ride along until the level that consumes the top chunk.
         for (int k = 1; k < STAGES; k++) begin
            opa_d[k] = opa_q[k-1];
            opb_d[k] = opb_q[k-1];
         end
         // Carry into the MSB recovered from the MSB sum bit and its operands.
         msb_cin = opa_q[STAGES-1][WIDTH-1] ^ opb_q[STAGES-1][WIDTH-1]
                 ^ sum_d[STAGES][WIDTH-1];
         ovf_d   = msb_cin ^ cy_d[STAGES];
         zero_d  = (sum_d[STAGES] == '0);
      end
   end

   // Pipeline registers; reset discards every in-flight beat at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q  <= '0;
         cy_q   <= '0;
         sum_q  <= '0;
         opa_q  <= '0;
         opb_q  <= '0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         vld_q  <= vld_d;
         cy_q   <= cy_d;
         sum_q  <= sum_d;
         opa_q  <= opa_d;
         opb_q  <= opb_d;
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end

   // Outputs come straight from the last level.
   always_comb begin
      out_valid = vld_q[STAGES];
      Sum       = sum_q[STAGES];
      C_out     = cy_q[STAGES];
      ovf       = ovf_q;
      zero      = zero_q;
   end

endmodule
